// File: rtl/ps2_keyb_receiver.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deframe and decode E0/F0 prefixed scan codes.
// Optional macro PS2_PARITY_CHECK_EN: reject frames with bad odd parity or a low stop bit.
module ps2_keyb_receiver #(
  parameter int wordsize       = 32,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [wordsize-1:0] keyb_char,
  output logic                key_valid,
  output logic                frame_err
);

  localparam int FCNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

  // The start bit is judged on the strobe that leaves IDLE, so no separate START state is held.
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic              clk_p0, clk_p1, dat_p0, dat_p1;
  logic              clk_filt;
  logic [FCNT_W-1:0] fcnt;
  logic              strobe;

  state_t            state, state_n;
  logic [2:0]        bitcnt, bitcnt_n;
  logic [7:0]        shreg, shreg_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic              ext, ext_n, brk, brk_n;
  logic [wordsize-1:0] char_n;
  logic              vld_n, err_n;
  logic              frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit, par_n;

  function automatic logic check_frame(input logic [7:0] d, input logic p, input logic s);
    return (^{d, p}) & s;
  endfunction

  assign frame_ok = check_frame(shreg, par_bit, dat_p1);
`else
  assign frame_ok = 1'b1;
`endif

  // Stage p0/p1: two-flop synchronisers, then the level filter on the clock line
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_p0   <= 1'b1;
      clk_p1   <= 1'b1;
      dat_p0   <= 1'b1;
      dat_p1   <= 1'b1;
      clk_filt <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
      if (clk_p1 == clk_filt) begin
        fcnt <= '0;
      end else if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_p1;
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Strobe fires in the cycle the filtered clock is about to fall.
  assign strobe = clk_filt & ~clk_p1 & (fcnt == FCNT_W'(FILTER_LEN - 1));

  // Stage p2: deframing FSM and scan-code decode
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    ext_n    = ext;
    brk_n    = brk;
    char_n   = keyb_char;
    vld_n    = 1'b0;
    err_n    = 1'b0;
    tcnt_n   = (strobe || state == IDLE) ? '0 : tcnt + TCNT_W'(1);
`ifdef PS2_PARITY_CHECK_EN
    par_n    = par_bit;
`endif
    case (state)
      IDLE: begin
        if (strobe) begin
          if (!dat_p1) begin
            state_n  = DATA;
            bitcnt_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_n  = {dat_p1, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
`ifdef PS2_PARITY_CHECK_EN
          par_n = dat_p1;
`endif
          state_n = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_n = IDLE;
          if (!frame_ok) begin
            err_n = 1'b1;
          end else if (shreg == 8'hE0) begin
            ext_n = 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_n = 1'b1;
          end else if (brk) begin
            if ({ext, shreg} == keyb_char[8:0]) char_n = '0;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end else begin
            char_n = wordsize'({ext, shreg});
            vld_n  = 1'b1;
            ext_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A stalled partial frame is abandoned; prefix state survives.
    if (state != IDLE && !strobe && tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      keyb_char <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      ext       <= ext_n;
      brk       <= brk_n;
      keyb_char <= char_n;
      key_valid <= vld_n;
      frame_err <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    bitcnt <= bitcnt_n;
    shreg  <= shreg_n;
`ifdef PS2_PARITY_CHECK_EN
    par_bit <= par_n;
`endif
  end

endmodule
